// File: rtl/amm_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : amm_burst_ram
// Brief    : Avalon-MM burst RAM slave with LFSR-driven latency/stall model.
// Revision : 1.0
// ============================================================================
module amm_burst_ram #(
    parameter int          DATA_W            = 64,
    parameter int          ADDR_W            = 10,
    parameter int          BURST_W           = 8,
    parameter int          RD_WAIT_MIN       = 1,
    parameter int          RD_WAIT_MAX       = 64,
    parameter int          WR_WAITREQ_CHANCE = 128,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [1:0]          speed_i,
    input  logic [ADDR_W-1:0]   amm_address_i,
    input  logic                amm_read_i,
    input  logic                amm_write_i,
    input  logic [DATA_W-1:0]   amm_writedata_i,
    input  logic [DATA_W/8-1:0] amm_byteenable_i,
    input  logic [BURST_W-1:0]  amm_burstcount_i,
    output logic [DATA_W-1:0]   amm_readdata_o,
    output logic                amm_readdatavalid_o,
    output logic                amm_waitrequest_o,
    output logic                protocol_err_o
);
    localparam int DEPTH     = 2**ADDR_W;
    localparam int BE_W      = DATA_W/8;
    localparam int WAIT_W    = $clog2(RD_WAIT_MAX+1);
    localparam int LAT_RANGE = RD_WAIT_MAX - RD_WAIT_MIN + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_WAIT  = 2'd1,
        S_RD_DATA  = 2'd2,
        S_WR_BURST = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_lfsr;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [BURST_W-1:0]  r_left, w_left_nxt;
    logic [WAIT_W-1:0]   r_wait, w_wait_nxt;
    logic                r_waitreq, w_waitreq_nxt;
    logic                r_rdv;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err, w_err_nxt;
    logic                w_emit, w_wr_en, w_accept, w_zero_bc;
    logic [ADDR_W-1:0]   w_rd_addr, w_wr_addr;
    logic [BURST_W-1:0]  w_len;
    logic [31:0]         w_lat;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    always_comb begin
        w_accept  = (amm_read_i | amm_write_i) & ~r_waitreq;
        w_zero_bc = (amm_burstcount_i == '0);
        w_len     = w_zero_bc ? BURST_W'(1) : amm_burstcount_i;
        case (speed_i)
            2'd0:    w_lat = 32'(RD_WAIT_MAX);
            2'd1:    w_lat = 32'(RD_WAIT_MIN);
            default: w_lat = 32'(RD_WAIT_MIN) + (32'(r_lfsr[15:8]) % 32'(LAT_RANGE));
        endcase
    end

    // r_left counts beats still to transfer; r_wait == 1 means the first beat is due now.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_left_nxt  = r_left;
        w_wait_nxt  = r_wait;
        w_err_nxt   = r_err;
        w_emit      = 1'b0;
        w_rd_addr   = r_addr;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_addr;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_zero_bc || (amm_read_i && amm_write_i))
                        w_err_nxt = 1'b1;
                    if (amm_write_i) begin
                        w_wr_en    = 1'b1;
                        w_wr_addr  = amm_address_i;
                        w_addr_nxt = amm_address_i + ADDR_W'(1);
                        w_left_nxt = w_len - BURST_W'(1);
                        if (w_len != BURST_W'(1))
                            w_state_nxt = S_WR_BURST;
                    end else if (w_lat == 32'd1) begin
                        w_emit     = 1'b1;
                        w_rd_addr  = amm_address_i;
                        w_addr_nxt = amm_address_i + ADDR_W'(1);
                        w_left_nxt = w_len - BURST_W'(1);
                        if (w_len != BURST_W'(1))
                            w_state_nxt = S_RD_DATA;
                    end else begin
                        w_addr_nxt  = amm_address_i;
                        w_left_nxt  = w_len;
                        w_wait_nxt  = WAIT_W'(w_lat - 32'd1);
                        w_state_nxt = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (r_wait == WAIT_W'(1)) begin
                    w_emit      = 1'b1;
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_left_nxt  = r_left - BURST_W'(1);
                    w_state_nxt = (r_left == BURST_W'(1)) ? S_IDLE : S_RD_DATA;
                end else begin
                    w_wait_nxt = r_wait - WAIT_W'(1);
                end
            end
            S_RD_DATA: begin
                w_emit     = 1'b1;
                w_addr_nxt = r_addr + ADDR_W'(1);
                w_left_nxt = r_left - BURST_W'(1);
                if (r_left == BURST_W'(1))
                    w_state_nxt = S_IDLE;
            end
            S_WR_BURST: begin
                if (amm_read_i)
                    w_err_nxt = 1'b1;
                if (amm_write_i && !r_waitreq) begin
                    w_wr_en    = 1'b1;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    w_left_nxt = r_left - BURST_W'(1);
                    if (r_left == BURST_W'(1))
                        w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt == S_RD_WAIT || w_state_nxt == S_RD_DATA)
            w_waitreq_nxt = 1'b1;
        else
            w_waitreq_nxt = (32'(r_lfsr[7:0]) < 32'(WR_WAITREQ_CHANCE));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_addr    <= '0;
            r_left    <= '0;
            r_wait    <= '0;
            r_waitreq <= 1'b1;
            r_rdv     <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_addr    <= w_addr_nxt;
            r_left    <= w_left_nxt;
            r_wait    <= w_wait_nxt;
            r_waitreq <= w_waitreq_nxt;
            r_rdv     <= w_emit;
            r_err     <= w_err_nxt;
            if (w_emit)
                r_rdata <= r_mem[w_rd_addr];
        end
    end

    // Memory is deliberately not reset; waitrequest is high during reset so no write can land.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (amm_byteenable_i[b])
                    r_mem[w_wr_addr][8*b +: 8] <= amm_writedata_i[8*b +: 8];
            end
        end
    end

    assign amm_readdata_o      = r_rdata;
    assign amm_readdatavalid_o = r_rdv;
    assign amm_waitrequest_o   = r_waitreq;
    assign protocol_err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_amm_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_amm_burst_ram
// Brief    : Directed self-checking bench for amm_burst_ram (DATA_W=32).
// Revision : 1.0
// ============================================================================
module tb_amm_burst_ram;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [1:0]  speed_i;
    logic [9:0]  amm_address_i;
    logic        amm_read_i, amm_write_i;
    logic [31:0] amm_writedata_i;
    logic [3:0]  amm_byteenable_i;
    logic [7:0]  amm_burstcount_i;
    logic [31:0] amm_readdata_o;
    logic        amm_readdatavalid_o, amm_waitrequest_o, protocol_err_o;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] beat_q [$];
    int          beat_c [$];
    logic [31:0] exp_d [8];

    amm_burst_ram #(
        .DATA_W(32), .ADDR_W(10), .BURST_W(8), .RD_WAIT_MIN(1), .RD_WAIT_MAX(64),
        .WR_WAITREQ_CHANCE(128), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .speed_i(speed_i),
        .amm_address_i(amm_address_i), .amm_read_i(amm_read_i), .amm_write_i(amm_write_i),
        .amm_writedata_i(amm_writedata_i), .amm_byteenable_i(amm_byteenable_i),
        .amm_burstcount_i(amm_burstcount_i), .amm_readdata_o(amm_readdata_o),
        .amm_readdatavalid_o(amm_readdatavalid_o), .amm_waitrequest_o(amm_waitrequest_o),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (amm_readdatavalid_o) begin
            beat_q.push_back(amm_readdata_o);
            beat_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic idle_bus();
        amm_read_i       = 1'b0;
        amm_write_i      = 1'b0;
        amm_burstcount_i = 8'd1;
        amm_byteenable_i = 4'h0;
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic issue(input logic rd, input logic wr, input logic [9:0] a, input logic [7:0] bc,
                         input logic [31:0] d, input logic [3:0] be, output int acc);
        bit done;
        done             = 1'b0;
        acc              = 0;
        amm_read_i       = rd;
        amm_write_i      = wr;
        amm_address_i    = a;
        amm_burstcount_i = bc;
        amm_writedata_i  = d;
        amm_byteenable_i = be;
        for (int i = 0; i < 500 && !done; i++) begin
            if (!amm_waitrequest_o) begin
                @(posedge clk_i);
                #1;
                acc  = cyc;
                done = 1'b1;
            end
            @(negedge clk_i);
        end
        if (!done)
            chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic write_burst(input logic [9:0] a, input int len, input logic [31:0] base,
                               input logic [3:0] be);
        int acc;
        for (int k = 0; k < len; k++)
            issue(1'b0, 1'b1, a, 8'(len), base + 32'(k), be, acc);
        idle_bus();
    endtask

    task automatic read_burst(input string tag, input logic [9:0] a, input logic [7:0] bc,
                              input logic [1:0] spd, input int n, input int lmin, input int lmax);
        int acc;
        int lat;
        beat_q.delete();
        beat_c.delete();
        speed_i = spd;
        issue(1'b1, 1'b0, a, bc, 32'h0, 4'h0, acc);
        idle_bus();
        speed_i = ~spd;
        for (int i = 0; i < 300 && beat_q.size() < n; i++) begin
            @(negedge clk_i);
            #1;
        end
        repeat (4) @(negedge clk_i);
        #1;
        chk({tag, ".count"}, 64'(beat_q.size()), 64'(n));
        if (beat_q.size() >= n) begin
            lat = beat_c[0] - acc + 1;
            if (lmin == lmax)
                chk({tag, ".latency"}, 64'(lat), 64'(lmin));
            else
                chk({tag, ".latency_in_range"}, 64'(lat >= lmin && lat <= lmax), 64'(1));
            chk({tag, ".consecutive"}, 64'(beat_c[n-1] - beat_c[0]), 64'(n - 1));
            for (int i = 0; i < n; i++)
                chk($sformatf("%s.beat%0d", tag, i), 64'(beat_q[i]), 64'(exp_d[i]));
        end
    endtask

    initial begin
        int acc;
        rst_n_i         = 1'b0;
        speed_i         = 2'd1;
        amm_address_i   = '0;
        amm_writedata_i = '0;
        idle_bus();
        repeat (3) @(negedge clk_i);
        chk("rst.waitrequest", 64'(amm_waitrequest_o), 64'(1));
        chk("rst.readdatavalid", 64'(amm_readdatavalid_o), 64'(0));
        chk("rst.readdata", 64'(amm_readdata_o), 64'(0));
        chk("rst.protocol_err", 64'(protocol_err_o), 64'(0));
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Single write then FAST single read: data back one cycle after accept
        write_burst(10'd5, 1, 32'h0000_A5A5, 4'hF);
        exp_d[0] = 32'h0000_A5A5;
        read_burst("fast_single", 10'd5, 8'd1, 2'd1, 1, 1, 1);

        // Byte-lane merge
        write_burst(10'd7, 1, 32'hFFFF_FFFF, 4'hF);
        write_burst(10'd7, 1, 32'h0000_1122, 4'b0011);
        exp_d[0] = 32'hFFFF_1122;
        read_burst("byteenable", 10'd7, 8'd1, 2'd1, 1, 1, 1);

        // Wrapping write and SLOW wrapping read
        write_burst(10'd1022, 4, 32'h1000_0000, 4'hF);
        for (int k = 0; k < 4; k++) exp_d[k] = 32'h1000_0000 + 32'(k);
        read_burst("slow_wrap", 10'd1022, 8'd4, 2'd0, 4, 64, 64);

        // 8-beat write under random stalls, read back FAST and RANDOM
        write_burst(10'd100, 8, 32'hC0DE_0000, 4'hF);
        for (int k = 0; k < 8; k++) exp_d[k] = 32'hC0DE_0000 + 32'(k);
        read_burst("burst8_fast", 10'd100, 8'd8, 2'd1, 8, 1, 1);
        read_burst("burst8_random", 10'd100, 8'd8, 2'd2, 8, 1, 64);
        chk("err_clean", 64'(protocol_err_o), 64'(0));

        // Burstcount 0 acts as 1 and latches the error flag
        issue(1'b0, 1'b1, 10'd200, 8'd0, 32'h0000_0077, 4'hF, acc);
        idle_bus();
        @(negedge clk_i);
        chk("bc0.err_set", 64'(protocol_err_o), 64'(1));
        exp_d[0] = 32'h0000_0077;
        read_burst("bc0_readback", 10'd200, 8'd1, 2'd1, 1, 1, 1);
        chk("bc0.err_sticky", 64'(protocol_err_o), 64'(1));

        // Reset in the middle of an 8-beat read
        write_burst(10'd300, 8, 32'h3000_0000, 4'hF);
        beat_q.delete();
        beat_c.delete();
        speed_i = 2'd1;
        issue(1'b1, 1'b0, 10'd300, 8'd8, 32'h0, 4'h0, acc);
        idle_bus();
        for (int i = 0; i < 100 && beat_q.size() < 2; i++) begin
            #1;
            if (beat_q.size() < 2) @(negedge clk_i);
        end
        rst_n_i = 1'b0;
        #1;
        chk("midrst.readdatavalid", 64'(amm_readdatavalid_o), 64'(0));
        chk("midrst.readdata", 64'(amm_readdata_o), 64'(0));
        chk("midrst.waitrequest", 64'(amm_waitrequest_o), 64'(1));
        chk("midrst.err_cleared", 64'(protocol_err_o), 64'(0));
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (10) @(negedge clk_i);
        #1;
        chk("midrst.no_more_beats", 64'(beat_q.size()), 64'(2));
        for (int k = 0; k < 8; k++) exp_d[k] = 32'h3000_0000 + 32'(k);
        read_burst("post_rst", 10'd300, 8'd8, 2'd1, 8, 1, 1);
        chk("post_rst.err", 64'(protocol_err_o), 64'(0));

        // Read and write together: write wins, read dropped, error latched
        beat_q.delete();
        issue(1'b1, 1'b1, 10'd400, 8'd1, 32'h0000_BEEF, 4'hF, acc);
        idle_bus();
        repeat (5) @(negedge clk_i);
        #1;
        chk("rdwr.err_set", 64'(protocol_err_o), 64'(1));
        chk("rdwr.read_ignored", 64'(beat_q.size()), 64'(0));
        exp_d[0] = 32'h0000_BEEF;
        read_burst("rdwr_readback", 10'd400, 8'd1, 2'd1, 1, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
